// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// One bit is converted per clock, so a conversion takes WIDTH shift cycles
// plus one DONE cycle. Any carry out of the top BCD digit is kept as a
// sticky overflow flag. The digits still hold the value modulo 10^DIGITS.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; bcd/ovf hold the last result
// SHIFT | one add-3/shift step per cycle, bit counter counting down
// DONE  | new bcd/ovf visible, done pulses, back to IDLE next cycle

module bin2bcd_seq #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [SW-1:0]       scr_q;
    logic [WIDTH-1:0]    sh_q;
    logic                sticky_q;
    logic [SW-1:0]       bcd_q;
    logic                ovf_q;

    logic [SW-1:0]       scr_adj;
    logic [SW+WIDTH:0]   cat_shl;
    logic                carry_out;
    logic [SW-1:0]       scr_nxt;
    logic [WIDTH-1:0]    sh_nxt;
    logic                last_shift;

    // Add 3 to every scratch digit that is 5 or more, all digits in parallel.
    always_comb begin
        scr_adj = scr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) begin
                scr_adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Shift the {scratch, binary} pair left by one bit.
    // Bit 0 is a zero fill. The top bit is whatever left the top digit.
    always_comb begin
        cat_shl   = {scr_adj, sh_q, 1'b0};
        carry_out = cat_shl[SW+WIDTH];
        scr_nxt   = cat_shl[SW+WIDTH-1:WIDTH];
        sh_nxt    = cat_shl[WIDTH-1:0];
    end

    assign last_shift = (cnt_q == CW'(1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_shift) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on an accepted start, then step once per SHIFT cycle.
    // The result registers load on the final shift edge so that bcd/ovf are
    // already valid during the DONE cycle, which is the cycle done is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            scr_q    <= '0;
            sh_q     <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sh_q     <= bin;
                        scr_q    <= '0;
                        sticky_q <= 1'b0;
                        cnt_q    <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    scr_q    <= scr_nxt;
                    sh_q     <= sh_nxt;
                    cnt_q    <= cnt_q - CW'(1);
                    sticky_q <= sticky_q | carry_out;
                    if (last_shift) begin
                        bcd_q <= scr_nxt;
                        ovf_q <= sticky_q | carry_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        bcd  = bcd_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq.
// Three instances are used: 6-bit/2-digit, 8-bit/2-digit and 16-bit/5-digit.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start6, start8, start16;
    logic [5:0]  bin6;
    logic [7:0]  bin8;
    logic [15:0] bin16;

    logic        busy6, done6, ovf6;
    logic [7:0]  bcd6;
    logic        busy8, done8, ovf8;
    logic [7:0]  bcd8;
    logic        busy16, done16, ovf16;
    logic [19:0] bcd16;

    int n_assert = 0;
    int n_fail   = 0;
    int cur      = 0;

    logic        o_busy, o_done, o_ovf;
    logic [39:0] o_bcd;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(6), .DIGITS(2)) u_dut6 (
        .clk(clk), .reset(reset), .start(start6), .bin(bin6),
        .busy(busy6), .done(done6), .bcd(bcd6), .ovf(ovf6)
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .bin(bin8),
        .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .bin(bin16),
        .busy(busy16), .done(done16), .bcd(bcd16), .ovf(ovf16)
    );

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        o_ovf  = 1'b0;
        o_bcd  = '0;
        case (cur)
            0: begin o_busy = busy6;  o_done = done6;  o_ovf = ovf6;  o_bcd = 40'(bcd6);  end
            1: begin o_busy = busy8;  o_done = done8;  o_ovf = ovf8;  o_bcd = 40'(bcd8);  end
            2: begin o_busy = busy16; o_done = done16; o_ovf = ovf16; o_bcd = 40'(bcd16); end
            default: begin end
        endcase
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, cur, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic st, input logic [31:0] b);
        case (sel)
            0: begin start6  = st; bin6  = b[5:0];  end
            1: begin start8  = st; bin8  = b[7:0];  end
            default: begin start16 = st; bin16 = b[15:0]; end
        endcase
    endtask

    // One conversion starting from an IDLE cycle.
    // The task returns in the IDLE cycle after DONE, so consecutive calls run back to back.
    // With disturb set, start is re-asserted and bin is changed while the converter is busy.
    task automatic conv(input int sel, input logic [31:0] b, input logic [39:0] exp_bcd,
                        input logic exp_ovf, input bit disturb);
        int w;
        w   = (sel == 0) ? 6 : (sel == 1) ? 8 : 16;
        cur = sel;
        drive(sel, 1'b1, b);
        tick();
        drive(sel, 1'b0, b);
        for (int c = 1; c <= w + 1; c++) begin
            if (disturb) begin
                if (c == 2) drive(sel, 1'b1, 32'd50);
                if (c == 3) drive(sel, 1'b1, 32'd21);
                if (c == 5) drive(sel, 1'b0, 32'd63);
            end
            check("busy_during", 40'(o_busy), 40'(1'b1));
            check("done_timing", 40'(o_done), 40'(c == w + 1));
            if (c == w + 1) begin
                check("bcd_result", o_bcd, exp_bcd);
                check("ovf_result", 40'(o_ovf), 40'(exp_ovf));
            end
            tick();
        end
        check("busy_after", 40'(o_busy), 40'(1'b0));
        check("done_after", 40'(o_done), 40'(1'b0));
        check("bcd_hold", o_bcd, exp_bcd);
        check("ovf_hold", 40'(o_ovf), 40'(exp_ovf));
    endtask

    initial begin
        reset   = 1'b1;
        start6  = 1'b0; start8 = 1'b0; start16 = 1'b0;
        bin6    = '0;   bin8   = '0;   bin16   = '0;
        tick();
        tick();

        // Check the outputs of all three instances while reset is held.
        for (int s = 0; s < 3; s++) begin
            cur = s;
            #1;
            check("rst_busy", 40'(o_busy), 40'(1'b0));
            check("rst_done", 40'(o_done), 40'(1'b0));
            check("rst_bcd",  o_bcd, 40'h0);
            check("rst_ovf",  40'(o_ovf), 40'(1'b0));
        end
        tick();
        reset = 1'b0;
        tick();

        // Single conversion of 45.
        conv(0, 32'd45, 40'h45, 1'b0, 1'b0);

        // Back-to-back sweep over the full 6-bit range.
        for (int b = 0; b < 64; b++) begin
            conv(0, 32'(b), 40'((b / 10) * 16 + (b % 10)), 1'b0, 1'b0);
        end

        // A start request and bin changes while busy must not affect the result.
        conv(0, 32'd12, 40'h12, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("no_extra_done", 40'(o_done), 40'(1'b0));
            check("no_extra_busy", 40'(o_busy), 40'(1'b0));
            tick();
        end

        // Reset in the middle of a conversion of 37.
        cur = 0;
        drive(0, 1'b1, 32'd37);
        tick();
        drive(0, 1'b0, 32'd37);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("abort_busy", 40'(o_busy), 40'(1'b0));
        check("abort_done", 40'(o_done), 40'(1'b0));
        check("abort_bcd",  o_bcd, 40'h0);
        check("abort_ovf",  40'(o_ovf), 40'(1'b0));
        tick();
        check("abort_done_held", 40'(o_done), 40'(1'b0));
        tick();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("post_rst_done", 40'(o_done), 40'(1'b0));
            check("post_rst_bcd",  o_bcd, 40'h0);
        end
        conv(0, 32'd37, 40'h37, 1'b0, 1'b0);

        // 8-bit input, 2 digits: overflow cases, and the sticky flag cleared on the next start.
        conv(1, 32'd255, 40'h55, 1'b1, 1'b0);
        conv(1, 32'd99,  40'h99, 1'b0, 1'b0);
        conv(1, 32'd100, 40'h00, 1'b1, 1'b0);
        conv(1, 32'd0,   40'h00, 1'b0, 1'b0);

        // 16-bit input, 5 digits.
        conv(2, 32'd65535, 40'h65535, 1'b0, 1'b0);
        conv(2, 32'd10000, 40'h10000, 1'b0, 1'b0);
        conv(2, 32'd0,     40'h00000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 6: binary input width, legal range 1..32.
REQ-002 Parameter DIGITS, default 2: number of BCD output digits, legal range 1..10.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 start  input  1: request a conversion of bin; sampled only in IDLE.
REQ-006 bin  input  WIDTH: unsigned binary value, captured on the accepted start.
REQ-007 busy  output  1: high from the cycle after an accepted start through the DONE cycle.
REQ-008 done  output  1: one-cycle pulse when bcd/ovf carry a new result.
REQ-009 bcd  output  4*DIGITS: packed BCD result, digit 0 (ones) in bits [3:0], digit k in bits [4k+3:4k].
REQ-010 ovf  output  1: high when the value does not fit in DIGITS digits; bcd then holds the low DIGITS decimal digits.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-012 IDLE with start=1: capture bin into the shift register, clear the digit scratch and sticky overflow, load the bit counter with WIDTH, go to SHIFT.
REQ-013 IDLE with start=0: remain in IDLE with outputs held.
REQ-014 Each SHIFT cycle, step 1: add 3 to every scratch digit whose value is 5 or more (all digits in parallel).
REQ-015 Each SHIFT cycle, step 2: shift the {scratch, binary} register left by one bit and decrement the counter.
REQ-016 A 1 shifted out of the top scratch digit SHALL set the sticky overflow flag.
REQ-017 After exactly WIDTH SHIFT cycles, move to DONE.
REQ-018 DONE, single cycle: load bcd from scratch, load ovf from the sticky flag, assert done, return to IDLE next cycle.
REQ-019 Latency: start accepted at edge 0 -> done high and bcd/ovf valid in cycle WIDTH+1; throughput one conversion per WIDTH+2 cycles.
REQ-020 start while busy (SHIFT or DONE) SHALL be ignored; bin changes during a conversion SHALL not affect the result.
REQ-021 bcd and ovf SHALL hold the last result until the next DONE cycle.
REQ-022 Every bcd digit SHALL be in 0..9 at all times.
REQ-023 When DIGITS is sufficient for 2^WIDTH-1, ovf SHALL never assert.
REQ-024 Start accepted in the IDLE cycle immediately after DONE SHALL be honoured (back-to-back operation).

Reset
REQ-025 On reset assertion, asynchronously: state=IDLE, busy=0, done=0, bcd=0, ovf=0, counter, scratch and shift register cleared.
REQ-026 Reset mid-conversion SHALL abort it; no done pulse for the aborted conversion; bcd reads 0.
REQ-027 After reset deassertion, the first start on a rising edge SHALL be accepted normally.

Verification
REQ-028 WIDTH=6, DIGITS=2, bin=45, start pulse -> busy high cycles 1..7, done in cycle 7 only, bcd=0x45, ovf=0.
REQ-029 WIDTH=6, DIGITS=2, sweep bin 0..63 back-to-back -> each bcd equals the decimal value (63 -> 0x63, 0 -> 0x00), done every 8 cycles, ovf=0.
REQ-030 WIDTH=8, DIGITS=2, bin=255 -> bcd=0x55, ovf=1; then bin=99 -> bcd=0x99, ovf=0 (sticky flag cleared per conversion).
REQ-031 WIDTH=6, start with bin=12, then start with bin=50 and changing bin during busy -> the single done reports bcd=0x12.
REQ-032 WIDTH=6, start bin=37, assert reset in cycle 3 -> outputs 0 immediately with no done; after release, start bin=37 -> bcd=0x37 at cycle 7.
REQ-033 WIDTH=16, DIGITS=5, bin=65535 -> done at cycle 17, bcd=0x65535, ovf=0.
